uart_fifo_bridge: RTL
=====================

Name: uart_fifo_bridge

Overview:
- Sits between the CPU bus and the existing byte UART (2-register map: status at a0=0, data at a0=1).
- Polls the UART autonomously:
  - drains received bytes into an RX FIFO;
  - feeds bytes from a TX FIFO into the transmitter.
- The CPU sees a 4-register buffered serial port, so it no longer has to service every byte at 115200 baud.

Parameters:
- DEPTH_LOG2, 4: log2 of each FIFO depth (16 entries each).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- a  in  2  CPU register select.
- din  in  8  CPU write data.
- dout  out  8  CPU read data (combinational).
- rnw  in  1  CPU 1=read, 0=write.
- cs  in  1  CPU select; one access per clk cycle in which cs=1.
- u_a0  out  1  to UART a0.
- u_din  out  8  to UART din.
- u_dout  in  8  from UART dout.
- u_rnw  out  1  to UART rnw.
- u_cs  out  1  to UART cs.

Behaviour:
- CPU register map:
  - a=0 status (read-only): bit0 rx_avail (RX not empty); bit1 tx_full; bit2 rx_fifo_full; bit3 tx_idle (TX FIFO empty and UART tx_busy=0); bit4 tx_drop (sticky); bits7:5 = 0.
  - a=1 data: a read returns the RX head and pops. Reading an empty FIFO returns 0x00, no pop. A write pushes din to TX. Writing a full FIFO drops the byte and sets tx_drop.
  - a=2 (read): {3'b0, rx_count[4:0]}, where rx_count ranges 0..16.
  - a=3 (write) control: bit0 flush RX, bit1 flush TX, bit2 clear tx_drop. Reads of a=3 return 0x00.
- Reset (reset=0 at posedge):
  - both FIFOs empty; tx_drop=0; FSM to POLL.
  - u_cs=0, u_rnw=1, u_a0=0, u_din=0x00. Reset overrides any in-progress sequence.
- UART-side FSM. Outputs are registered and each state lasts exactly one cycle unless a transition is noted.
  - POLL: u_cs=1, u_rnw=1, u_a0=0. Sample u_dout[0] as rx_full and u_dout[1] as tx_busy at the posedge.
    - If rx_full=1 and the RX FIFO is not full → RX_LATCH.
    - Else if tx_busy=0 and the TX FIFO is not empty → TX_WRITE.
    - Else stay in POLL.
    - RX has priority over TX.
  - RX_LATCH: u_cs=0, u_a0=1, u_rnw=1. Push u_dout into RX at the posedge → RX_ACK.
    - The data is captured with cs low because the UART clears its buffer on the negedge of a selected data read.
  - RX_ACK: u_cs=1, u_a0=1, u_rnw=1. Clears the UART receive buffer → POLL.
  - TX_WRITE: u_cs=1, u_a0=1, u_rnw=0, u_din = TX head. Pop TX at the posedge → TX_GUARD.
  - TX_GUARD: u_cs=0 for one cycle, so tx_busy is visible before the next poll → POLL.
- While the RX FIFO is full, received bytes are held in the UART and are not read; later UART overruns are not detected.
- Simultaneous events:
  - CPU pop and FSM push of RX in the same cycle: both happen; count unchanged.
  - CPU push and FSM pop of TX in the same cycle: both happen. A push while full is dropped even if a pop occurs in the same cycle.
  - Flush in the same cycle as a push or pop: flush wins and the FIFO ends empty. A flush of TX during TX_WRITE still lets the already-driven byte be written to the UART.
- Pointers are DEPTH_LOG2 bits and wrap modulo the depth. The count is DEPTH_LOG2+1 bits, giving an unambiguous full/empty state.

Decomposition:
- Shared package constants:
  - register offsets REG_STATUS=0, REG_DATA=1, REG_COUNT=2, REG_CTRL=3;
  - status bit positions;
  - FSM state encoding (POLL, RX_LATCH, RX_ACK, TX_WRITE, TX_GUARD);
  - UART-side offsets (status=0, data=1) and UART status bits (rx_full=0, tx_busy=1).
- One sub-module, sync_fifo: 8-bit width, DEPTH_LOG2 parameter, push/pop/flush, full/empty/count outputs. It is instantiated twice (RX and TX).

Test Plan:
- Reset, then read a=0 → 0x08 (tx_idle=1 only); read a=2 → 0x00; u_cs=0 during reset.
- Behavioural UART model presents rx_full with byte 0x5A → sequence POLL, RX_LATCH, RX_ACK (u_cs=1, u_a0=1, u_rnw=1) observed; CPU reads a=0 → bit0=1, a=1 → 0x5A, then a=2 → 0x00.
- CPU writes 0x41, 0x42, 0x43 → UART model sees three u_cs&!u_rnw&u_a0 writes in order 0x41, 0x42, 0x43, each only after its tx_busy drops; afterwards status bit3=1.
- 16 RX bytes arrive with no CPU reads → status bit2=1 and count=0x10. A 17th byte stays in the UART with no RX_LATCH. One CPU pop → the 17th byte is drained; count returns to 16.
- Write 17 bytes while the UART is held busy → status bit1=1 and bit4=1, 17th byte absent on the wire. Write a=3 with 0x06 → TX empty, tx_drop=0.
- Assert reset mid RX_LATCH → next cycle FSM is in POLL, u_cs=0, count=0.

Source files
------------

// File: rtl/uart_fifo_bridge_pkg.sv
// uart_fifo_bridge_pkg: CPU register map, status bits, UART-side map and FSM encoding
package uart_fifo_bridge_pkg;
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_TX_IDLE  = 3;
    localparam int ST_TX_DROP  = 4;

    localparam int CTRL_FLUSH_RX = 0;
    localparam int CTRL_FLUSH_TX = 1;
    localparam int CTRL_CLR_DROP = 2;

    localparam logic U_STATUS = 1'b0;
    localparam logic U_DATA   = 1'b1;
    localparam int U_RX_FULL = 0;
    localparam int U_TX_BUSY = 1;

    typedef enum logic [2:0] {POLL, RX_LATCH, RX_ACK, TX_WRITE, TX_GUARD} state_t;

    typedef struct packed {
        logic       cs;
        logic       rnw;
        logic       a0;
        logic [7:0] din;
    } ubus_t;

    localparam ubus_t UBUS_IDLE = '{cs: 1'b0, rnw: 1'b1, a0: 1'b0, din: 8'h00};
endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// sync_fifo: 8-bit synchronous FIFO; pushes while full and pops while empty are ignored, flush wins
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int N = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = N[DEPTH_LOG2:0];

    logic [7:0]            mem_q [N];
    logic [DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic                  do_push, do_pop;

    assign full    = cnt_q == FULL_CNT;
    assign empty   = cnt_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + DEPTH_LOG2'(do_push);
            rd_q  <= rd_q + DEPTH_LOG2'(do_pop);
            cnt_q <= cnt_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: buffered 4-register CPU port in front of a 2-register byte UART,
// with an FSM that polls the UART, drains RX bytes and feeds TX bytes autonomously.
module uart_fifo_bridge
    import uart_fifo_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] a,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rnw,
    input  logic       cs,
    output logic       u_a0,
    output logic [7:0] u_din,
    input  logic [7:0] u_dout,
    output logic       u_rnw,
    output logic       u_cs
);
    state_t state_q, state_d;
    ubus_t  ubus_q, ubus_d;
    logic   tx_busy_q, tx_drop_q;
    logic   rx_push, rx_pop, rx_full, rx_empty, tx_push, tx_pop, tx_full, tx_empty;
    logic   flush_rx, flush_tx, clr_drop, tx_idle;
    logic [7:0] rx_head, tx_head, status;
    logic [DEPTH_LOG2:0] rx_count, tx_count;

    assign rx_pop   = cs && rnw && a == REG_DATA;
    assign tx_push  = cs && !rnw && a == REG_DATA;
    assign flush_rx = cs && !rnw && a == REG_CTRL && din[CTRL_FLUSH_RX];
    assign flush_tx = cs && !rnw && a == REG_CTRL && din[CTRL_FLUSH_TX];
    assign clr_drop = cs && !rnw && a == REG_CTRL && din[CTRL_CLR_DROP];
    assign rx_push  = state_q == RX_LATCH;
    assign tx_pop   = state_q == TX_WRITE;
    assign tx_idle  = tx_count == '0 && !tx_busy_q;

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .flush(flush_rx),
        .wdata(u_dout), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .flush(flush_tx),
        .wdata(din), .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    always_comb begin
        status = 8'h00;
        status[ST_RX_AVAIL] = !rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_IDLE]  = tx_idle;
        status[ST_TX_DROP]  = tx_drop_q;
    end

    assign dout = a == REG_STATUS ? status :
                  a == REG_DATA   ? (rx_empty ? 8'h00 : rx_head) :
                  a == REG_COUNT  ? 8'(rx_count) : 8'h00;

    // RX takes priority; a full RX FIFO leaves the byte waiting inside the UART
    always_comb begin
        state_d = state_q;
        case (state_q)
            POLL:     state_d = (u_dout[U_RX_FULL] && !rx_full) ? RX_LATCH :
                                (!u_dout[U_TX_BUSY] && !tx_empty) ? TX_WRITE : POLL;
            RX_LATCH: state_d = RX_ACK;
            TX_WRITE: state_d = TX_GUARD;
            default:  state_d = POLL;
        endcase
    end

    // UART bus is registered from the next state; RX_LATCH reads data with cs low
    always_comb begin
        ubus_d.cs  = state_d inside {POLL, RX_ACK, TX_WRITE};
        ubus_d.rnw = state_d != TX_WRITE;
        ubus_d.a0  = state_d inside {RX_LATCH, RX_ACK, TX_WRITE} ? U_DATA : U_STATUS;
        ubus_d.din = state_d == TX_WRITE ? tx_head : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= POLL;
            ubus_q    <= UBUS_IDLE;
            tx_busy_q <= 1'b0;
            tx_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ubus_q    <= ubus_d;
            tx_busy_q <= state_q == POLL ? u_dout[U_TX_BUSY] : state_q == TX_WRITE ? 1'b1 : tx_busy_q;
            tx_drop_q <= (tx_drop_q && !clr_drop) || (tx_push && tx_full);
        end
    end

    assign u_cs  = ubus_q.cs;
    assign u_rnw = ubus_q.rnw;
    assign u_a0  = ubus_q.a0;
    assign u_din = ubus_q.din;
endmodule
